// File: rtl/sm_trace_monitor.sv
// sm_trace_monitor: circular instruction trace capture with a streamed dump of
// the trace followed by a RAM snapshot, triggered by timeout or manual request.
module sm_trace_monitor #(
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned NCYCLE      = 1000,
    parameter int unsigned RAM_WORDS   = 16,
    parameter int unsigned RAM_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [31:0]       pc,
    input  logic [31:0]       instr,
    input  logic              dump_req,
    output logic [RAM_AW-1:0] ramAddr,
    input  logic [31:0]       ramData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_kind,
    output logic [7:0]        out_index,
    output logic [31:0]       out_aux,
    output logic [31:0]       out_data,
    output logic [31:0]       cycle_cnt,
    output logic              timeout,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int unsigned FW = $clog2(TRACE_DEPTH + 1);
    localparam int unsigned IW = 8;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        TRACE_DUMP = 2'd1,
        RAM_DUMP   = 2'd2,
        DONE       = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_entry_t;

    trace_entry_t mem [TRACE_DEPTH];

    state_e            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]     filled_q, filled_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;
    logic              out_kind_q, out_kind_d;
    logic [IW-1:0]     out_index_q, out_index_d;
    logic [31:0]       out_aux_q, out_aux_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;

    logic              capture;
    logic              xfer;
    trace_entry_t      cap_entry;
    trace_entry_t      rd_entry;

    assign capture   = (state_q == RUN) && en;
    assign xfer      = out_valid_q && out_ready;
    assign cap_entry = '{pc: pc, instr: instr};

    // Trace storage: synchronous write, no reset (contents hidden while filled is 0)
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr_q] <= cap_entry;
        end
    end

    // State and registered-output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            filled_q    <= '0;
            idx_q       <= '0;
            cycle_cnt_q <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_kind_q  <= 1'b0;
            out_index_q <= '0;
            out_aux_q   <= '0;
            out_data_q  <= '0;
            ram_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            filled_q    <= filled_d;
            idx_q       <= idx_d;
            cycle_cnt_q <= cycle_cnt_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_kind_q  <= out_kind_d;
            out_index_q <= out_index_d;
            out_aux_q   <= out_aux_d;
            out_data_q  <= out_data_d;
            ram_addr_q  <= ram_addr_d;
        end
    end

    // Next-state: capture in RUN, then walk trace oldest-first, then RAM words
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        filled_d    = filled_q;
        idx_d       = idx_q;
        cycle_cnt_d = cycle_cnt_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            RUN: begin
                if (en) begin
                    wr_ptr_d    = wr_ptr_q + PW'(1);
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                    if (filled_q != FW'(TRACE_DEPTH)) begin
                        filled_d = filled_q + FW'(1);
                    end
                end
                if (en && (cycle_cnt_q == 32'(NCYCLE - 1))) begin
                    timeout_d = 1'b1;
                    state_d   = TRACE_DUMP;
                end else if (dump_req) begin
                    state_d = TRACE_DUMP;
                end
                if (state_d == TRACE_DUMP) begin
                    // Full buffer truncates filled to 0 here, making rd == wr (oldest slot)
                    rd_ptr_d = wr_ptr_d - PW'(filled_d);
                    idx_d    = '0;
                end
            end
            TRACE_DUMP: begin
                if (filled_q == '0) begin
                    state_d = RAM_DUMP;
                    idx_d   = '0;
                end else if (xfer) begin
                    if ((9'(idx_q) + 9'd1) == 9'(filled_q)) begin
                        state_d = RAM_DUMP;
                        idx_d   = '0;
                    end else begin
                        idx_d    = idx_q + IW'(1);
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
            end
            RAM_DUMP: begin
                if (xfer) begin
                    if (9'(idx_q) == 9'(RAM_WORDS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Trace read with bypass: the oldest entry may be the one written this edge
    always_comb begin
        rd_entry = mem[rd_ptr_d];
        if (capture && (rd_ptr_d == wr_ptr_q)) begin
            rd_entry = cap_entry;
        end
    end

    // Registered outputs are decoded from the upcoming state so they align with it
    always_comb begin
        busy_d      = (state_d == TRACE_DUMP) || (state_d == RAM_DUMP);
        done_d      = (state_d == DONE);
        out_valid_d = ((state_d == TRACE_DUMP) && (filled_d != '0)) || (state_d == RAM_DUMP);
        out_kind_d  = (state_d == RAM_DUMP);
        out_index_d = '0;
        out_aux_d   = '0;
        out_data_d  = '0;
        ram_addr_d  = '0;
        if (state_d == TRACE_DUMP) begin
            out_index_d = idx_d;
            out_aux_d   = rd_entry.pc;
            out_data_d  = rd_entry.instr;
        end else if (state_d == RAM_DUMP) begin
            out_index_d = idx_d;
            ram_addr_d  = RAM_AW'(idx_d);
        end
    end

    assign ramAddr   = ram_addr_q;
    assign out_valid = out_valid_q;
    assign out_kind  = out_kind_q;
    assign out_index = out_index_q;
    assign out_aux   = out_aux_q;
    assign out_data  = (state_q == RAM_DUMP) ? ramData : out_data_q;
    assign cycle_cnt = cycle_cnt_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sm_trace_monitor.sv
// Directed self-checking bench for sm_trace_monitor (depth 4, 8-cycle timeout, 8 RAM words).
module tb_sm_trace_monitor;

    localparam int unsigned TRACE_DEPTH = 4;
    localparam int unsigned NCYCLE      = 8;
    localparam int unsigned RAM_WORDS   = 8;
    localparam int unsigned RAM_AW      = 5;

    typedef logic [72:0] word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              dump_req;
    logic [RAM_AW-1:0] ramAddr;
    logic [31:0]       ramData;
    logic              out_valid;
    logic              out_ready;
    logic              out_kind;
    logic [7:0]        out_index;
    logic [31:0]       out_aux;
    logic [31:0]       out_data;
    logic [31:0]       cycle_cnt;
    logic              timeout;
    logic              busy;
    logic              done;

    int    n_checks = 0;
    int    n_fail   = 0;
    word_t got_q[$];

    sm_trace_monitor #(
        .TRACE_DEPTH(TRACE_DEPTH),
        .NCYCLE     (NCYCLE),
        .RAM_WORDS  (RAM_WORDS),
        .RAM_AW     (RAM_AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pc       (pc),
        .instr    (instr),
        .dump_req (dump_req),
        .ramAddr  (ramAddr),
        .ramData  (ramData),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_kind (out_kind),
        .out_index(out_index),
        .out_aux  (out_aux),
        .out_data (out_data),
        .cycle_cnt(cycle_cnt),
        .timeout  (timeout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [RAM_AW-1:0] a);
        return 32'h5A00_0000 + (32'(a) * 32'h0000_0101);
    endfunction

    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return p ^ 32'hFFFF_0000;
    endfunction

    assign ramData = ram_word(ramAddr);

    function automatic word_t tw(input int i, input logic [31:0] p);
        return {1'b0, 8'(i), p, instr_of(p)};
    endfunction

    function automatic word_t rw(input int i);
        return {1'b1, 8'(i), 32'h0, ram_word(RAM_AW'(i))};
    endfunction

    function automatic word_t snap();
        return {out_kind, out_index, out_aux, out_data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; dump_req = 1'b0; out_ready = 1'b0;
        pc = '0; instr = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic capture(input logic [31:0] p);
        en = 1'b1; pc = p; instr = instr_of(p);
        step();
        en = 1'b0;
    endtask

    // Accept every valid word until done rises or the cycle budget runs out
    task automatic drain(input int max_cycles, output bit finished);
        got_q.delete();
        finished  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            if (done) break;
            if (out_valid) got_q.push_back(snap());
            step();
        end
        finished  = done;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; dump_req = 1'b0; out_ready = 1'b0;
        pc = '0; instr = '0;
        #2;
        n_checks++;
        if ({cycle_cnt, timeout, busy, done} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_status: got cnt=%h to=%b busy=%b done=%b, expected all 0", cycle_cnt, timeout, busy, done);
        end
        n_checks++;
        if ({out_valid, snap(), ramAddr} !== 79'h0) begin
            n_fail++;
            $display("FAIL reset_stream: got valid=%b word=%h addr=%h, expected all 0", out_valid, snap(), ramAddr);
        end
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if ({cycle_cnt, busy, out_valid} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got cnt=%h busy=%b valid=%b, expected 0", cycle_cnt, busy, out_valid);
        end
    endtask

    task automatic test_timeout();
        bit    fin;
        word_t exp_q[$];
        do_reset();
        for (int k = 0; k < 7; k++) capture(32'(k));
        n_checks++;
        if ({cycle_cnt, timeout, busy} !== {32'd7, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_before: got cnt=%0d to=%b busy=%b, expected 7 0 0", cycle_cnt, timeout, busy);
        end
        capture(32'd7);
        n_checks++;
        if ({cycle_cnt, timeout, busy, out_valid} !== {32'd8, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_hit: got cnt=%0d to=%b busy=%b valid=%b, expected 8 1 1 1", cycle_cnt, timeout, busy, out_valid);
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(tw(k, 32'(4 + k)));
        for (int k = 0; k < int'(RAM_WORDS); k++) exp_q.push_back(rw(k));
        drain(60, fin);
        n_checks++;
        if (!fin || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL timeout_stream_len: got %0d words done=%b, expected %0d words done=1", got_q.size(), fin, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL timeout_word%0d: got %h expected %h", k, got_q[k], exp_q[k]);
            end
        end
        n_checks++;
        if ({done, busy, out_valid, ramAddr} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL done_state: got done=%b busy=%b valid=%b addr=%h, expected 1 0 0 0", done, busy, out_valid, ramAddr);
        end
        en = 1'b1; dump_req = 1'b1; pc = 32'h99;
        repeat (3) step();
        en = 1'b0; dump_req = 1'b0;
        n_checks++;
        if ({cycle_cnt, done, busy} !== {32'd8, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL done_ignores_inputs: got cnt=%0d done=%b busy=%b, expected 8 1 0", cycle_cnt, done, busy);
        end
    endtask

    task automatic test_dump_req();
        bit    fin;
        word_t exp_q[$];
        do_reset();
        for (int k = 10; k < 16; k++) capture(32'(k));
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        n_checks++;
        if ({cycle_cnt, timeout, busy} !== {32'd6, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL dumpreq_status: got cnt=%0d to=%b busy=%b, expected 6 0 1", cycle_cnt, timeout, busy);
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(tw(k, 32'(12 + k)));
        for (int k = 0; k < int'(RAM_WORDS); k++) exp_q.push_back(rw(k));
        drain(60, fin);
        n_checks++;
        if (!fin || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL dumpreq_stream_len: got %0d words done=%b, expected %0d words done=1", got_q.size(), fin, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL dumpreq_word%0d: got %h expected %h", k, got_q[k], exp_q[k]);
            end
        end
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL dumpreq_timeout: got %b expected 0", timeout);
        end
    endtask

    task automatic test_stall();
        logic        pat [4];
        word_t       prev;
        bit          prev_stall;
        logic [31:0] seen[$];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        prev = '0;
        prev_stall = 1'b0;
        do_reset();
        for (int k = 20; k < 23; k++) capture(32'(k));
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            out_ready = pat[c % 4];
            #1;
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || snap() !== prev) begin
                    n_fail++;
                    $display("FAIL stall_hold_c%0d: got valid=%b word=%h expected 1 %h", c, out_valid, snap(), prev);
                end
            end
            prev       = snap();
            prev_stall = out_valid && !out_ready;
            if (out_valid && out_ready && !out_kind) seen.push_back(out_aux);
            step();
        end
        out_ready = 1'b0;
        n_checks++;
        if (seen.size() != 3) begin
            n_fail++;
            $display("FAIL stall_count: got %0d trace transfers expected 3", seen.size());
        end
        for (int k = 0; k < 3 && k < seen.size(); k++) begin
            n_checks++;
            if (seen[k] !== 32'(20 + k)) begin
                n_fail++;
                $display("FAIL stall_entry%0d: got pc %0d expected %0d", k, seen[k], 20 + k);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        n_checks++;
        if ({busy, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL empty_trace_state: got busy=%b valid=%b expected 1 0", busy, out_valid);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || snap() !== rw(0) || ramAddr !== 5'd0) begin
            n_fail++;
            $display("FAIL empty_first_word: got valid=%b word=%h expected 1 %h", out_valid, snap(), rw(0));
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && out_index != 8'd5; c++) step();
        out_ready = 1'b0;
        n_checks++;
        if (snap() !== rw(5) || ramAddr !== 5'd5) begin
            n_fail++;
            $display("FAIL ram_idx5: got word=%h addr=%0d expected %h 5", snap(), ramAddr, rw(5));
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, busy, ramAddr, out_data, out_index} !== 47'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: got valid=%b busy=%b addr=%h data=%h idx=%0d expected all 0", out_valid, busy, ramAddr, out_data, out_index);
        end
        #1;
        rst = 1'b0;
        step();
        n_checks++;
        if ({cycle_cnt, busy} !== 33'h0) begin
            n_fail++;
            $display("FAIL midreset_idle: got cnt=%0d busy=%b expected 0 0", cycle_cnt, busy);
        end
        en = 1'b1; pc = 32'd100; instr = instr_of(32'd100); dump_req = 1'b1;
        step();
        en = 1'b0; dump_req = 1'b0;
        n_checks++;
        if (cycle_cnt !== 32'd1 || out_valid !== 1'b1 || snap() !== tw(0, 32'd100)) begin
            n_fail++;
            $display("FAIL fresh_dump_first: got cnt=%0d valid=%b word=%h expected 1 1 %h", cycle_cnt, out_valid, snap(), tw(0, 32'd100));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (snap() !== rw(0)) begin
            n_fail++;
            $display("FAIL fresh_dump_ram0: got %h expected %h", snap(), rw(0));
        end
    endtask

    task automatic test_en_gaps();
        do_reset();
        repeat (50) step();
        n_checks++;
        if ({cycle_cnt, timeout, busy} !== 34'h0) begin
            n_fail++;
            $display("FAIL idle_count: got cnt=%0d to=%b busy=%b expected 0 0 0", cycle_cnt, timeout, busy);
        end
        for (int k = 0; k < 7; k++) capture(32'(200 + k));
        n_checks++;
        if ({cycle_cnt, timeout} !== {32'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL gaps_before: got cnt=%0d to=%b expected 7 0", cycle_cnt, timeout);
        end
        capture(32'd207);
        n_checks++;
        if ({cycle_cnt, timeout, ramAddr} !== {32'd8, 1'b1, 5'd0} || snap() !== tw(0, 32'd204)) begin
            n_fail++;
            $display("FAIL gaps_timeout: got cnt=%0d to=%b addr=%0d word=%h expected 8 1 0 %h", cycle_cnt, timeout, ramAddr, snap(), tw(0, 32'd204));
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_dump_req();
        test_stall();
        test_reset_mid();
        test_en_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_trace_monitor.md
SM_TRACE_MONITOR -- requirements
Module: sm_trace_monitor

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
  TRACE_DEPTH, 16, trace entries (power of 2, 2..256)
  NCYCLE, 1000, enabled cycles before timeout (>=1)
  RAM_WORDS, 16, words dumped (1..256)
  RAM_AW, 5, RAM word-address width
REQ-003 Ports SHALL be, one per line:
  clk  in  1  clock
  rst  in  1  async reset, active-high
  en  in  1  core executed an instruction this cycle
  pc  in  32  PC of current instruction
  instr  in  32  current instruction word
  dump_req  in  1  manual dump request (level, sampled in RUN)
  ramAddr  out  RAM_AW  RAM read address
  ramData  in  32  RAM read data, combinational from ramAddr
  out_valid  out  1  dump stream word valid
  out_ready  in  1  dump stream sink ready
  out_kind  out  1  0 = trace entry, 1 = RAM word
  out_index  out  8  entry/word index within its kind
  out_aux  out  32  trace: pc; RAM: zero
  out_data  out  32  trace: instr; RAM: ramData
  cycle_cnt  out  32  enabled cycles counted
  timeout  out  1  NCYCLE reached
  busy  out  1  dump in progress
  done  out  1  dump finished

Function
REQ-004 FSM states SHALL be RUN, TRACE_DUMP, RAM_DUMP, DONE; reset state RUN.
REQ-005 In RUN with en=1, SHALL write {pc,instr} at wr_ptr, increment wr_ptr modulo TRACE_DEPTH, increment filled saturating at TRACE_DEPTH, and increment cycle_cnt, all on the same edge.
REQ-006 In RUN, if en=1 and cycle_cnt==NCYCLE-1, the capture of REQ-005 SHALL occur, then timeout SHALL be set to 1 and the state SHALL move to TRACE_DUMP.
REQ-007 In RUN, dump_req=1 SHALL move to TRACE_DUMP on the next edge; any capture that cycle still occurs; timeout is set only under REQ-006.
REQ-008 On entering TRACE_DUMP, the read pointer SHALL be (wr_ptr - filled) mod TRACE_DEPTH; entries are emitted oldest-first.
REQ-009 In TRACE_DUMP with filled==0, the state SHALL go directly to RAM_DUMP without asserting out_valid.
REQ-010 In TRACE_DUMP, out_valid=1, out_kind=0, out_index=k (0..filled-1), out_aux=pc[k], out_data=instr[k].
REQ-011 A word SHALL advance only on out_valid&&out_ready; while out_ready=0, all out_* SHALL hold stable.
REQ-012 After the transfer of entry filled-1, the state SHALL move to RAM_DUMP with index 0.
REQ-013 In RAM_DUMP, ramAddr=index, out_valid=1, out_kind=1, out_index=index, out_aux=0, out_data=ramData (combinational pass-through).
REQ-014 After the transfer of word RAM_WORDS-1, the state SHALL move to DONE.
REQ-015 In DONE, out_valid=0, busy=0, done=1; the state SHALL persist until reset; en and dump_req are ignored.
REQ-016 busy SHALL be 1 exactly in TRACE_DUMP and RAM_DUMP.
REQ-017 cycle_cnt, wr_ptr and filled SHALL not change outside RUN.
REQ-018 ramAddr SHALL be 0 outside RAM_DUMP.
REQ-019 Trace storage SHALL be register or LUT RAM with synchronous write and combinational read.

Reset
REQ-020 On rst=1, the block SHALL asynchronously enter RUN with the following cleared to 0: cycle_cnt, wr_ptr, filled, index, timeout, done, busy, out_valid, out_kind, out_index, out_aux, out_data, ramAddr.
REQ-021 Trace storage contents SHALL not be reset and are unobservable because filled=0.
REQ-022 A reset during TRACE_DUMP or RAM_DUMP SHALL abort the dump, and the partial stream SHALL be dropped.

Verification
REQ-023 TRACE_DEPTH=4, NCYCLE=3, en=1, pc=0,1,2 -> timeout=1 after 3rd edge; stream: (kind0, idx0, pc0), (idx1, pc1), (idx2, pc2), then RAM words 0..RAM_WORDS-1; done=1.
REQ-024 TRACE_DEPTH=4, 6 captures (pc=10..15), then dump_req -> trace entries pc=12,13,14,15 in order, timeout=0.
REQ-025 dump_req with no prior en -> no kind0 words; first out word is kind1 idx0 with out_data=ram[0].
REQ-026 out_ready toggled 1,0,0,1 during the trace dump -> each word delivered exactly once, with outputs stable while stalled.
REQ-027 rst asserted mid-RAM_DUMP (index 5) -> out_valid=0 immediately, then cycle_cnt counts from 0 and a fresh dump starts at trace idx0.
REQ-028 en=0 for 50 cycles, then en=1 -> cycle_cnt counts only enabled cycles, and timeout is reached at exactly NCYCLE enabled edges.
